four_to_two_rr_encoder: RTL and testbench

FOUR_TO_TWO_RR_ENCODER -- requirements
Module: four_to_two_rr_encoder

---
 rtl/four_to_two_rr_encoder.sv | 92 +++++++++
 tb/tb_four_to_two_rr_encoder.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/four_to_two_rr_encoder.sv
// Encodes four level request lines (D0..D3) into a registered 2-bit index with valid.
// A request seen before an edge appears after that edge; while V=1 and RDY=0 the code holds and new requests are pended.
module four_to_two_rr_encoder #(
  parameter int unsigned RR_EN = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic D0,
  input  logic D1,
  input  logic D2,
  input  logic D3,
  input  logic RDY,
  output logic A,
  output logic B,
  output logic V
);

  logic [3:0] r_pend;
  logic [1:0] r_ptr;
  logic       r_a;
  logic       r_b;
  logic       r_v;

  logic [3:0] w_req;
  logic [3:0] w_cand;
  logic       w_free;
  logic       w_load;
  logic [1:0] w_sel_rr;
  logic [1:0] w_sel_fp;
  logic [1:0] w_sel;
  logic [1:0] w_idx;
  logic       w_hit;
  logic [3:0] w_sel_mask;
  logic [3:0] w_pend_nxt;

  assign w_req  = {D3, D2, D1, D0};
  assign w_cand = r_pend | w_req;
  // The output slot is free when empty or when its code leaves on this edge.
  assign w_free = !r_v || RDY;
  assign w_load = w_free && (w_cand != 4'b0000);

  // Search starts one past the last grant and wraps back to it.
  always_comb begin
    w_sel_rr = r_ptr;
    w_hit    = 1'b0;
    w_idx    = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_hit && w_cand[w_idx]) begin
        w_sel_rr = w_idx;
        w_hit    = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_fp = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (w_cand[k]) begin
        w_sel_fp = 2'(k);
      end
    end
  end

  assign w_sel      = (RR_EN != 0) ? w_sel_rr : w_sel_fp;
  assign w_sel_mask = 4'b0001 << w_sel;
  assign w_pend_nxt = w_load ? (w_cand & ~w_sel_mask) : w_cand;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= 4'b0000;
      r_ptr  <= 2'b11;
      r_a    <= 1'b0;
      r_b    <= 1'b0;
      r_v    <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_load) begin
        {r_a, r_b} <= w_sel;
        r_v        <= 1'b1;
        r_ptr      <= w_sel;
      end else if (w_free) begin
        r_v <= 1'b0;
      end
    end
  end

  assign A = r_a;
  assign B = r_b;
  assign V = r_v;

endmodule

// File: tb/tb_four_to_two_rr_encoder.sv
// Bench for four_to_two_rr_encoder: round-robin and fixed-priority instances share stimulus
// and are checked against a request-list reference model.
module tb_four_to_two_rr_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] d   = 4'b0000;
  logic       rdy = 1'b0;
  logic       a_rr, b_rr, v_rr;
  logic       a_fp, b_fp, v_fp;
  int         n_cmp = 0;
  int         n_err = 0;

  // Model state, index 0 = round-robin instance, 1 = fixed-priority instance.
  bit m_pend [2][4];
  int m_last [2];
  int m_code [2];
  bit m_valid[2];

  always #5 clk = ~clk;

  four_to_two_rr_encoder #(.RR_EN(1)) u_rr (
    .clk(clk), .rst(rst), .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
    .RDY(rdy), .A(a_rr), .B(b_rr), .V(v_rr)
  );

  four_to_two_rr_encoder #(.RR_EN(0)) u_fp (
    .clk(clk), .rst(rst), .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
    .RDY(rdy), .A(a_fp), .B(b_fp), .V(v_fp)
  );

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 4; i++) m_pend[m][i] = 1'b0;
      m_last[m]  = 3;
      m_code[m]  = 0;
      m_valid[m] = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    for (int m = 0; m < 2; m++) begin
      bit c[4];
      bit any;
      bit free;
      int s;
      any  = 1'b0;
      s    = -1;
      free = !m_valid[m] || rdy;
      for (int i = 0; i < 4; i++) begin
        c[i] = m_pend[m][i] || d[i];
        any  = any || c[i];
      end
      if (m == 0) begin
        for (int k = 1; k <= 4; k++)
          if (s < 0 && c[(m_last[m] + k) % 4]) s = (m_last[m] + k) % 4;
      end else begin
        for (int i = 3; i >= 0; i--)
          if (s < 0 && c[i]) s = i;
      end
      if (free && any) begin
        m_code[m]  = s;
        m_valid[m] = 1'b1;
        m_last[m]  = s;
        c[s]       = 1'b0;
      end else if (free) begin
        m_valid[m] = 1'b0;
      end
      for (int i = 0; i < 4; i++) m_pend[m][i] = c[i];
    end
  endfunction

  function automatic logic [2:0] model_out(int m);
    logic [1:0] code;
    code = 2'(m_code[m]);
    return {code, m_valid[m]};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    d   = 4'b1111;
    rdy = 1'b1;
    #2;
    rst = 1'b1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if ({a_rr, b_rr, v_rr} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_hold_rr cyc=%0d got=%b want=000", k, {a_rr, b_rr, v_rr});
      end
      n_cmp++;
      if ({a_fp, b_fp, v_fp} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_hold_fp cyc=%0d got=%b want=000", k, {a_fp, b_fp, v_fp});
      end
    end
    d   = 4'b0000;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (v_rr !== 1'b0 || v_fp !== 1'b0) begin
        n_err++;
        $display("FAIL reset_release_idle cyc=%0d got_v=%b%b want=00", k, v_rr, v_fp);
      end
    end
  endtask

  task automatic test_single();
    logic [1:0] want;
    do_reset();
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d    = 4'b0001 << i;
      want = 2'(i);
      tick();
      d = 4'b0000;
      n_cmp++;
      if ({a_rr, b_rr, v_rr} !== {want, 1'b1} || {a_fp, b_fp, v_fp} !== {want, 1'b1}) begin
        n_err++;
        $display("FAIL single_grant D%0d got_rr=%b got_fp=%b want=%b1", i,
                 {a_rr, b_rr, v_rr}, {a_fp, b_fp, v_fp}, want);
      end
      tick();
      n_cmp++;
      if (v_rr !== 1'b0 || v_fp !== 1'b0) begin
        n_err++;
        $display("FAIL single_one_cycle D%0d got_v=%b%b want=00", i, v_rr, v_fp);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] want;
    do_reset();
    rdy = 1'b1;
    d   = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      want = 2'(k % 4);
      tick();
      n_cmp++;
      if ({a_rr, b_rr, v_rr} !== {want, 1'b1}) begin
        n_err++;
        $display("FAIL rr_rotation cyc=%0d got=%b want=%b1", k, {a_rr, b_rr, v_rr}, want);
      end
      n_cmp++;
      if ({a_fp, b_fp, v_fp} !== 3'b111) begin
        n_err++;
        $display("FAIL fp_all_held cyc=%0d got=%b want=111", k, {a_fp, b_fp, v_fp});
      end
    end
    d = 4'b0000;
  endtask

  task automatic test_fixed_priority();
    do_reset();
    rdy = 1'b1;
    d   = 4'b0101;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_cmp++;
      if ({a_fp, b_fp, v_fp} !== 3'b101) begin
        n_err++;
        $display("FAIL fp_priority cyc=%0d got=%b want=101", k, {a_fp, b_fp, v_fp});
      end
      n_cmp++;
      if ({a_rr, b_rr, v_rr} !== model_out(0)) begin
        n_err++;
        $display("FAIL rr_two_req cyc=%0d got=%b want=%b", k, {a_rr, b_rr, v_rr}, model_out(0));
      end
    end
    // D0 stayed pending behind D2 and must surface once D2 drops.
    d = 4'b0000;
    tick();
    n_cmp++;
    if ({a_fp, b_fp, v_fp} !== 3'b001) begin
      n_err++;
      $display("FAIL fp_pending_d0 got=%b want=001", {a_fp, b_fp, v_fp});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] want;
    do_reset();
    rdy = 1'b1;
    d   = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick();
      d    = 4'b0000;
      want = 2'(k);
      n_cmp++;
      if ({a_rr, b_rr, v_rr} !== {want, 1'b1}) begin
        n_err++;
        $display("FAIL b2b_rr cyc=%0d got=%b want=%b1", k, {a_rr, b_rr, v_rr}, want);
      end
      want = 2'(3 - k);
      n_cmp++;
      if ({a_fp, b_fp, v_fp} !== {want, 1'b1}) begin
        n_err++;
        $display("FAIL b2b_fp cyc=%0d got=%b want=%b1", k, {a_fp, b_fp, v_fp}, want);
      end
    end
    tick();
    n_cmp++;
    if (v_rr !== 1'b0 || v_fp !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drain got_v=%b%b want=00", v_rr, v_fp);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    rdy = 1'b0;
    d   = 4'b0010;
    tick();
    d = 4'b0000;
    tick();
    d = 4'b1000;
    tick();
    d = 4'b0000;
    tick();
    n_cmp++;
    if ({a_rr, b_rr, v_rr} !== 3'b011 || {a_fp, b_fp, v_fp} !== 3'b011) begin
      n_err++;
      $display("FAIL bp_hold got_rr=%b got_fp=%b want=011", {a_rr, b_rr, v_rr}, {a_fp, b_fp, v_fp});
    end
    rdy = 1'b1;
    tick();
    n_cmp++;
    if ({a_rr, b_rr, v_rr} !== 3'b111 || {a_fp, b_fp, v_fp} !== 3'b111) begin
      n_err++;
      $display("FAIL bp_next got_rr=%b got_fp=%b want=111", {a_rr, b_rr, v_rr}, {a_fp, b_fp, v_fp});
    end
    tick();
    n_cmp++;
    if (v_rr !== 1'b0 || v_fp !== 1'b0) begin
      n_err++;
      $display("FAIL bp_drain got_v=%b%b want=00", v_rr, v_fp);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rdy = 1'b0;
    d   = 4'b0001;
    tick();
    d = 4'b1010;
    tick();
    d = 4'b0000;
    n_cmp++;
    if ({a_rr, b_rr, v_rr} !== 3'b001) begin
      n_err++;
      $display("FAIL midrst_setup got=%b want=001", {a_rr, b_rr, v_rr});
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if ({a_rr, b_rr, v_rr} !== 3'b000 || {a_fp, b_fp, v_fp} !== 3'b000) begin
      n_err++;
      $display("FAIL midrst_async got_rr=%b got_fp=%b want=000", {a_rr, b_rr, v_rr}, {a_fp, b_fp, v_fp});
    end
    tick();
    rdy = 1'b1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if (v_rr !== 1'b0 || v_fp !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_no_stale cyc=%0d got_v=%b%b want=00", k, v_rr, v_fp);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      d   = 4'($urandom) & 4'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      tick();
      n_cmp++;
      if ({a_rr, b_rr, v_rr} !== model_out(0)) begin
        n_err++;
        $display("FAIL rand_rr cyc=%0d got=%b want=%b", k, {a_rr, b_rr, v_rr}, model_out(0));
      end
      n_cmp++;
      if ({a_fp, b_fp, v_fp} !== model_out(1)) begin
        n_err++;
        $display("FAIL rand_fp cyc=%0d got=%b want=%b", k, {a_fp, b_fp, v_fp}, model_out(1));
      end
    end
    d = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_priority();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
